// File: rtl/rf_fifo_pkg.sv
// rtl/rf_fifo_pkg.sv - shared constants and helpers for the rf_fifo controller
// Purpose: output buffer depth, macro read latency and level-width helper.
// Ports: none (package).
package rf_fifo_pkg;

  // Words held in the output buffer behind the RAM read port.
  localparam int OBUF_DEPTH = 2;

  // Cycles from CENA low to QA valid on the rfdp macro.
  localparam int RD_LATENCY = 1;

  // Level counts RAM words, buffered words and one in-flight read.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + OBUF_DEPTH + 1);
  endfunction

endpackage

// File: rtl/rf_fifo_obuf.sv
// rtl/rf_fifo_obuf.sv - 2-entry output buffer presenting the FIFO head word
// Purpose: holds words captured from the RAM read port; head is registered.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, din  capture a word (never while full unless popping)
//   pop        remove the head word (only while valid)
//   valid      head word present
//   dout       head word
//   cnt        words held (0..2)
module rf_fifo_obuf
  import rf_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] e0;  // head
  logic [WIDTH-1:0] e1;  // second entry

  assign valid = (cnt != 2'd0);
  assign dout  = e0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Replace the departing head; with two words the tail moves up.
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf_fifo_ctrl.sv
// rtl/rf_fifo_ctrl.sv - FWFT FIFO controller for an external rfdp dual-port RAM
// Purpose: write side on macro port B, prefetching read side on port A feeding
//   a 2-entry output buffer so the stream runs at one word per cycle.
// Optional: RF_FIFO_ALMOST_FULL_EN adds parameter AF_THRESH and output almost_full.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data      write stream
//   out_valid/out_ready/out_data   read stream (first word fall through)
//   level                          words held (RAM + buffer + in-flight read)
//   almost_full                    level >= AF_THRESH, registered (optional)
//   ram_aa/ram_cena/ram_qa         macro read port A
//   ram_ab/ram_db/ram_cenb         macro write port B
module rf_fifo_ctrl
  import rf_fifo_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
`ifdef RF_FIFO_ALMOST_FULL_EN
  parameter int AF_THRESH = DEPTH - 16,
`endif
  localparam int AW = $clog2(DEPTH),
  localparam int LW = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
`ifdef RF_FIFO_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic [AW-1:0]    ram_aa,
  output logic             ram_cena,
  input  logic [WIDTH-1:0] ram_qa,
  output logic [AW-1:0]    ram_ab,
  output logic [WIDTH-1:0] ram_db,
  output logic             ram_cenb
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  logic [AW:0]   ram_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_pend;
  logic [1:0]    obuf_cnt;
  logic [2:0]    occ;
  logic          wr_en;
  logic          rd_en;
  logic          pop;

  assign in_ready = !rst && (ram_cnt != RAM_FULL);
  assign wr_en    = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Issue a read only if the word still fits in the buffer once it lands,
  // counting the read already in flight and any pop this cycle.
  assign occ   = {1'b0, obuf_cnt} + {2'b00, rd_pend};
  assign rd_en = !rst && (ram_cnt != '0) && (occ <= (3'd1 + {2'b00, pop}));

  assign ram_cenb = !wr_en;
  assign ram_ab   = wr_ptr;
  assign ram_db   = in_data;
  assign ram_cena = !rd_en;
  assign ram_aa   = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      level   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;  // wraps: DEPTH is a power of two
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt <= ram_cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      rd_pend <= rd_en;
      // Every accepted word stays counted until popped, wherever it sits.
      level   <= level + LW'(wr_en) - LW'(pop);
    end
  end

  rf_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .din   (ram_qa),
    .pop   (pop),
    .valid (out_valid),
    .dout  (out_data),
    .cnt   (obuf_cnt)
  );

`ifdef RF_FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (int'(level) >= AF_THRESH);
  end
`endif

endmodule

// File: doc/rf_fifo_ctrl.md
Name: rf_fifo_ctrl

Overview:
Synchronous FIFO controller that drives one external rfdp-style dual-port RAM macro (e.g. rfdp512x32). Write side uses port B, read side uses port A.
- Converts the macro's 1-cycle registered-address read into a first-word-fall-through valid/ready stream.
- Adds a 2-entry output buffer so the stream sustains full throughput.
- Sits between JPEG pipeline stages wherever a deep elastic buffer is needed.

Parameters:
DEPTH, 512, RAM word count; power of 2, >= 8; must match the attached macro
WIDTH, 32, data word width; must match the macro
AW, $clog2(DEPTH), RAM address width (derived, not overridden)
LW, $clog2(DEPTH+3), width of the level output (derived)

Ports:
clk  in  1  single clock; also drives the macro's CLKA and CLKB at integration
rst  in  1  synchronous, active-high reset
in_valid  in  1  write request
in_ready  out  1  write accept; transfer when in_valid & in_ready
in_data  in  WIDTH  write data
out_valid  out  1  head word present
out_ready  in  1  consumer accept; pop when out_valid & out_ready
out_data  out  WIDTH  head word
level  out  LW  words held: RAM + output buffer + in-flight read
ram_aa  out  AW  macro read address (AA)
ram_cena  out  1  macro read enable, active low (CENA)
ram_qa  in  WIDTH  macro read data (QA), valid the cycle after CENA low
ram_ab  out  AW  macro write address (AB)
ram_db  out  WIDTH  macro write data (DB)
ram_cenb  out  1  macro write enable, active low (CENB)

Behaviour:
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_pend=0, obuf empty. Outputs: out_valid=0, level=0, ram_cena=1, ram_cenb=1. in_ready=0 while rst is high; in_ready=1 in the first cycle after reset.
- in_ready = !rst & (ram_cnt != DEPTH).
- Write: on accept, drive ram_cenb=0, ram_ab=wr_ptr, ram_db=in_data in the same cycle (combinational). wr_ptr increments and wraps modulo DEPTH.
- Read issue (combinational), condition: ram_cnt != 0 and (obuf_cnt + rd_pend - pop) <= 1.
  - When issued: ram_cena=0, ram_aa=rd_ptr; rd_ptr wraps modulo DEPTH; rd_pend<=1 for the next cycle.
- Capture: when rd_pend=1, ram_qa is pushed into obuf. Capture and pop may occur in the same cycle.
- ram_cnt update: ram_cnt <= ram_cnt + write - issue.
- No read/write address collision can occur: a read requires ram_cnt > 0 and a write requires ram_cnt < DEPTH.
- Total capacity is DEPTH+2 words. in_ready depends only on ram_cnt, so the last two words land in obuf via prefetch.
- Latency: word accepted in cycle 0 (empty FIFO) -> read issued cycle 1 -> captured end of cycle 2 -> out_valid=1 in cycle 3.
- Throughput: 1 word/cycle sustained in both directions.
- level = ram_cnt + obuf_cnt + rd_pend; registered; max DEPTH+2.
- out_data and out_valid come from the obuf head register; no combinational path from ram_qa to out_data.
- Reset mid-operation: all contents discarded; no stale word is ever presented after reset.

Optional Feature:
RF_FIFO_ALMOST_FULL_EN:
- Defined: adds parameter AF_THRESH (default DEPTH-16) and output almost_full (1 bit, registered). almost_full=1 iff level >= AF_THRESH; reset value 0.
- Undefined: neither the port nor the parameter exists; all other behaviour is identical.

Decomposition:
- Package rf_fifo_pkg: OBUF_DEPTH=2, RD_LATENCY=1, and the function lvl_width(depth) returning $clog2(depth+OBUF_DEPTH+1).
- Sub-module rf_fifo_obuf: 2-entry valid/ready buffer with push/pop, obuf_cnt output and head data.
- The RAM macro is instantiated by the parent, not inside this block.

Test Plan:
- Reset, write 0xDEADBEEF once with out_ready=1 -> out_valid=1 exactly 3 cycles after accept with out_data=0xDEADBEEF; level goes 1,1,1,0.
- out_ready=0, in_valid held high -> exactly 514 accepts (DEPTH=512); in_ready=0 after; level=514; ram_cnt never exceeds 512.
- Continuous writes with out_ready=1 -> after the 3-cycle fill, one word out every cycle, in order, no bubbles; level steady at 3.
- 10,000 words, random in_valid/out_ready at 50% each -> scoreboard matches order and data; pointer wrap exercised at least 15 times.
- Fill to level=100, assert rst for 1 cycle -> next cycle out_valid=0, level=0, in_ready=1; the first later write is the first word read out.
- With RF_FIFO_ALMOST_FULL_EN and AF_THRESH=500 -> almost_full rises the cycle after level reaches 500 and falls after level drops to 499.
